// File: rtl/letter_decode_fifo.sv
// One-hot letter decoder feeding a DEPTH-entry FIFO of {err, code} entries.
// Optional saturating invalid-letter counter enabled by defining LETTER_ERRCNT_EN.
module letter_decode_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [25:0]              in_letter,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [4:0]               out_code,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a transfer happens on a rising edge when valid && ready on that side.
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          letter_ok;
  logic [4:0]    letter_code;
  logic [5:0]    entry_d;
  logic [5:0]    head;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    letter_ok   = (in_letter != '0) && ((in_letter & (in_letter - 26'd1)) == '0);
    letter_code = '0;
    for (int i = 0; i < 26; i++) begin
      if (in_letter[i]) letter_code = letter_code | 5'(i);
    end
    entry_d = letter_ok ? {1'b0, letter_code} : 6'b100000;
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A full FIFO refuses input even when the head leaves on the same edge.
  assign push  = in_valid && !full;
  assign pop   = out_ready && !empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= entry_d;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head      = mem_q[rptr_q];
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_code  = empty ? 5'd0 : head[4:0];
  assign out_err   = empty ? 1'b0 : head[5];
  assign count     = count_q;

`ifdef LETTER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (push && !letter_ok && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_letter_decode_fifo.sv
// Directed and randomized bench for letter_decode_fifo against a queue-based model.
module tb_letter_decode_fifo;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [25:0] in_letter;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_code;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic [7:0]  err_count;

  letter_decode_fifo #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_letter (in_letter),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [5:0] exp_q[$];
  int         model_err;
  int         total_cnt;
  int         pass_cnt;

  function automatic logic [5:0] model_decode(input logic [25:0] l);
    for (int k = 0; k < 26; k++) begin
      if (l == (26'd1 << k)) return {1'b0, 5'(k)};
    end
    return 6'b100000;
  endfunction

  function automatic logic [25:0] rand_letter();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 26'd1 << $urandom_range(0, 25);
    if (r == 7) return 26'd0;
    return 26'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    logic [5:0] h;
    int         ec;
    h = (exp_q.size() > 0) ? exp_q[0] : 6'd0;
`ifdef LETTER_ERRCNT_EN
    ec = model_err;
`else
    ec = 0;
`endif
    chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    chk({tag, ".out_code"},  32'(out_code),  32'(h[4:0]));
    chk({tag, ".out_err"},   32'(out_err),   32'(h[5]));
    chk({tag, ".count"},     32'(count),     32'(exp_q.size()));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
  endtask

  // Drive one cycle, advance the model with the pre-edge occupancy, then check.
  task automatic cycle(input string tag, input logic v, input logic [25:0] l, input logic r);
    logic       do_push;
    logic       do_pop;
    logic [5:0] e;
    in_valid  = v;
    in_letter = l;
    out_ready = r;
    do_push = v && (exp_q.size() < DEPTH);
    do_pop  = r && (exp_q.size() > 0);
    e = model_decode(l);
    @(posedge clock);
    #1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      exp_q.push_back(e);
      if (e[5] && model_err < 255) model_err++;
    end
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    exp_q.delete();
    model_err = 0;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    model_err = 0;
    in_valid  = 1'b0;
    in_letter = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    #2;
    apply_reset();
    @(negedge clock);

    cycle("single_push", 1'b1, 26'h0000001, 1'b0);
    cycle("single_pop",  1'b0, 26'h0,       1'b1);

    cycle("fill_z", 1'b1, 26'd1 << 25, 1'b0);
    cycle("fill_m", 1'b1, 26'd1 << 12, 1'b0);
    cycle("fill_b", 1'b1, 26'd1 << 1,  1'b0);
    cycle("fill_y", 1'b1, 26'd1 << 24, 1'b0);
    cycle("over_c", 1'b1, 26'd1 << 2,  1'b0);
    repeat (4) cycle("drain", 1'b0, 26'h0, 1'b1);

    cycle("inv_zero", 1'b1, 26'h0000000, 1'b0);
    cycle("inv_two",  1'b1, 26'h0000003, 1'b0);
    repeat (2) cycle("inv_drain", 1'b0, 26'h0, 1'b1);

    cycle("wrap_pre1", 1'b1, rand_letter(), 1'b0);
    cycle("wrap_pre2", 1'b1, rand_letter(), 1'b0);
    repeat (6) cycle("wrap_pp", 1'b1, 26'd1 << $urandom_range(0, 25), 1'b1);
    repeat (2) cycle("full_pre", 1'b1, 26'd1 << $urandom_range(0, 25), 1'b0);
    cycle("full_pp", 1'b1, 26'd1 << 7, 1'b1);
    repeat (3) cycle("full_drain", 1'b0, 26'h0, 1'b1);

    repeat (3) cycle("mid_fill", 1'b1, rand_letter(), 1'b0);
    apply_reset();
    cycle("post_rst_e", 1'b1, 26'd1 << 4, 1'b0);
    cycle("post_rst_pop", 1'b0, 26'h0, 1'b1);

    repeat (5) cycle("empty_pop", 1'b0, 26'h0, 1'b1);
    cycle("after_empty_push", 1'b1, 26'd1 << 9, 1'b0);
    cycle("after_empty_pop",  1'b0, 26'h0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      cycle("sat", 1'b1, ($urandom_range(0, 1) == 0) ? 26'h0 : (26'h3 << $urandom_range(0, 24)), 1'b1);
    end
    cycle("sat_drain", 1'b0, 26'h0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), rand_letter(), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
